// File: rtl/mem_port_arbiter.sv
// Arbitrates one unified memory port between fetch (IF) and data (DM).
// Ports: if_*/dm_* requesters, mem_* registered command, stalls out.
module mem_port_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MAX_DSTREAK = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_ack,
  output logic                if_stall,
  input  logic                dm_req,
  input  logic                dm_we,
  input  logic [DATA_W/8-1:0] dm_be,
  input  logic [ADDR_W-1:0]   dm_addr,
  input  logic [DATA_W-1:0]   dm_wdata,
  output logic [DATA_W-1:0]   dm_rdata,
  output logic                dm_ack,
  output logic                dm_stall,
  output logic                mem_req,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ready
);

  localparam int BE_W = DATA_W / 8;
  localparam int SW   = $clog2(MAX_DSTREAK + 1);
  localparam logic [SW-1:0] SMAX = SW'(MAX_DSTREAK);

  typedef enum logic [1:0] {
    IDLE,
    IF_BUSY,
    DM_BUSY
  } state_t;

  state_t        state, stateNext;
  logic [SW-1:0] dstreak, dstreakNext;
  logic          grantIf, grantDm;

  always_comb begin
    stateNext   = state;
    dstreakNext = dstreak;
    grantIf     = 1'b0;
    grantDm     = 1'b0;
    unique case (state)
      IDLE: begin
        // Fetch wins only when alone or when the DM streak is used up.
        grantIf = if_req & (~dm_req | (dstreak == SMAX));
        grantDm = dm_req & ~grantIf;
        unique case (1'b1)
          grantIf: begin
            stateNext   = IF_BUSY;
            dstreakNext = '0;
          end
          grantDm: begin
            stateNext = DM_BUSY;
            if (!if_req)
              dstreakNext = '0;
            else if (dstreak != SMAX)
              dstreakNext = dstreak + 1'b1;
          end
          default: ;
        endcase
      end
      IF_BUSY, DM_BUSY: begin
        if (mem_ready)
          stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      dstreak   <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state   <= stateNext;
      dstreak <= dstreakNext;
      mem_req <= (stateNext != IDLE);
      if (grantIf) begin
        mem_we   <= 1'b0;
        mem_be   <= {BE_W{1'b1}};
        mem_addr <= if_addr;
      end else if (grantDm) begin
        mem_we    <= dm_we;
        mem_be    <= dm_be;
        mem_addr  <= dm_addr;
        mem_wdata <= dm_wdata;
      end
    end
  end

  // An in-flight command abandoned by reset must not acknowledge.
  assign if_ack   = ~rst & (state == IF_BUSY) & mem_ready;
  assign dm_ack   = ~rst & (state == DM_BUSY) & mem_ready;
  assign if_rdata = mem_rdata;
  assign dm_rdata = mem_rdata;
  assign if_stall = if_req & ~if_ack;
  assign dm_stall = dm_req & ~dm_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed cases then random traffic
// checked each cycle against a transaction-level reference model.
module tb_mem_port_arbiter;

  localparam int MAXD = 4;

  logic        clk;
  logic        rst;
  logic        ifReq;
  logic [31:0] ifAddr;
  logic [31:0] ifRdata;
  logic        ifAck;
  logic        ifStall;
  logic        dmReq;
  logic        dmWe;
  logic [3:0]  dmBe;
  logic [31:0] dmAddr;
  logic [31:0] dmWdata;
  logic [31:0] dmRdata;
  logic        dmAck;
  logic        dmStall;
  logic        memReq;
  logic        memWe;
  logic [3:0]  memBe;
  logic [31:0] memAddr;
  logic [31:0] memWdata;
  logic [31:0] memRdata;
  logic        memReady;

  mem_port_arbiter #(
    .ADDR_W(32),
    .DATA_W(32),
    .MAX_DSTREAK(MAXD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .if_req(ifReq),
    .if_addr(ifAddr),
    .if_rdata(ifRdata),
    .if_ack(ifAck),
    .if_stall(ifStall),
    .dm_req(dmReq),
    .dm_we(dmWe),
    .dm_be(dmBe),
    .dm_addr(dmAddr),
    .dm_wdata(dmWdata),
    .dm_rdata(dmRdata),
    .dm_ack(dmAck),
    .dm_stall(dmStall),
    .mem_req(memReq),
    .mem_we(memWe),
    .mem_be(memBe),
    .mem_addr(memAddr),
    .mem_wdata(memWdata),
    .mem_rdata(memRdata),
    .mem_ready(memReady)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: who owns the port (0 none, 1 IF, 2 DM),
  // the DM streak count and the command the memory should see.
  int          owner = 0;
  int          streak = 0;
  logic        mReq = 0;
  logic        mWe = 0;
  logic [3:0]  mBe = 0;
  logic [31:0] mAddr = 0;
  logic [31:0] mWdata = 0;
  logic        chkEn = 0;
  logic        lastIfAck = 0;
  logic        lastDmAck = 0;
  string       acks = "";

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    logic eIf;
    logic eDm;
    #3;
    eIf = (owner == 1) && memReady && !rst;
    eDm = (owner == 2) && memReady && !rst;
    if (chkEn) begin
      chk("mem_req", 64'(memReq), 64'(mReq));
      chk("mem_we", 64'(memWe), 64'(mWe));
      chk("mem_be", 64'(memBe), 64'(mBe));
      chk("mem_addr", 64'(memAddr), 64'(mAddr));
      chk("mem_wdata", 64'(memWdata), 64'(mWdata));
      chk("if_ack", 64'(ifAck), 64'(eIf));
      chk("dm_ack", 64'(dmAck), 64'(eDm));
      chk("if_stall", 64'(ifStall), 64'(ifReq & ~eIf));
      chk("dm_stall", 64'(dmStall), 64'(dmReq & ~eDm));
      if (eIf) chk("if_rdata", 64'(ifRdata), 64'(memRdata));
      if (eDm) chk("dm_rdata", 64'(dmRdata), 64'(memRdata));
    end
    if (ifAck === 1'b1) acks = {acks, "I"};
    if (dmAck === 1'b1) acks = {acks, "D"};
    lastIfAck = eIf;
    lastDmAck = eDm;
    @(posedge clk);
    if (rst) begin
      owner = 0; streak = 0; mReq = 0; mWe = 0;
      mBe = 0; mAddr = 0; mWdata = 0;
    end else if (owner == 0) begin
      if (ifReq && (!dmReq || streak == MAXD)) begin
        owner = 1; streak = 0;
        mWe = 0; mBe = 4'hF; mAddr = ifAddr;
      end else if (dmReq) begin
        owner = 2;
        if (!ifReq) streak = 0;
        else if (streak < MAXD) streak = streak + 1;
        mWe = dmWe; mBe = dmBe;
        mAddr = dmAddr; mWdata = dmWdata;
      end
      mReq = (owner != 0);
    end else if (memReady) begin
      owner = 0;
      mReq = 0;
    end
    #1;
  endtask

  task automatic chkStr(input string tag,
                        input string obs,
                        input string exp);
    vectors++;
    assert (obs == exp) else begin
      miscompares++;
      $error("FAIL %s: observed %s expected %s", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1; ifReq = 0; ifAddr = 0;
    dmReq = 0; dmWe = 0; dmBe = 0; dmAddr = 0; dmWdata = 0;
    memRdata = 0; memReady = 0;
    cyc();
    chkEn = 1;
    cyc();
    rst = 0;
    cyc();

    // Single fetch, latency 1.
    ifReq = 1; ifAddr = 32'h100;
    cyc();
    memReady = 1; memRdata = 32'hDEADBEEF;
    cyc();
    ifReq = 0; memReady = 0;
    cyc();

    // Store, latency 3.
    dmReq = 1; dmWe = 1; dmBe = 4'h3;
    dmAddr = 32'h2004; dmWdata = 32'h1234;
    cyc();
    cyc();
    cyc();
    memReady = 1;
    cyc();
    dmReq = 0; memReady = 0;
    cyc();

    // Simultaneous requests: DM first, then IF.
    acks = "";
    ifReq = 1; ifAddr = 32'h200;
    dmReq = 1; dmWe = 0; dmAddr = 32'h3000;
    memReady = 1; memRdata = 32'h55AA55AA;
    cyc();
    cyc();
    dmReq = 0;
    cyc();
    cyc();
    ifReq = 0;
    memReady = 0;
    cyc();
    chkStr("simul_order", acks, "DI");

    // Starvation cap with both held high, latency 1.
    acks = "";
    ifReq = 1; dmReq = 1; memReady = 1;
    for (int i = 0; i < 20; i++) cyc();
    ifReq = 0; dmReq = 0; memReady = 0;
    cyc();
    cyc();
    chkStr("streak_cap", acks, "DDDDIDDDDI");

    // Reset during the 2nd busy cycle of a DM load.
    dmReq = 1; dmWe = 0; dmAddr = 32'h40;
    cyc();
    cyc();
    rst = 1;
    cyc();
    rst = 0; dmReq = 0;
    cyc();
    memReady = 1;
    cyc();
    cyc();

    // mem_ready while idle does nothing.
    for (int i = 0; i < 3; i++) cyc();
    memReady = 0;
    cyc();

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      if (lastIfAck) begin
        ifReq = 1'($urandom_range(0, 1));
        ifAddr = $urandom;
      end else if (!ifReq && $urandom_range(0, 3) == 0) begin
        ifReq = 1; ifAddr = $urandom;
      end
      if (lastDmAck) begin
        dmReq = 1'($urandom_range(0, 1));
        dmWe = 1'($urandom); dmBe = 4'($urandom);
        dmAddr = $urandom; dmWdata = $urandom;
      end else if (!dmReq && $urandom_range(0, 2) == 0) begin
        dmReq = 1;
        dmWe = 1'($urandom); dmBe = 4'($urandom);
        dmAddr = $urandom; dmWdata = $urandom;
      end
      if ($urandom_range(0, 49) == 0) ifReq = 0;
      if ($urandom_range(0, 49) == 0) dmReq = 0;
      if (owner != 0) memReady = ($urandom_range(0, 2) == 0);
      else memReady = ($urandom_range(0, 4) == 0);
      memRdata = $urandom;
      rst = ($urandom_range(0, 99) == 0);
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
